mem_arbiter: RTL and testbench

Parametrised N-port memory arbiter that shares one backing memory port between the CPU's instruction fetch, data access and future masters (debug, DMA, CLINT). It replaces the per-port cache instances hard-wired to a shared `memReady` with one block. The block serialises requests, grants by round-robin or fixed priority, returns read data per port and drives the CPU-facing global `nostall`. It sits between the CPU/cache front ends and the single memory/bus slave.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_grant.sv | 30 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM encoding and default widths for mem_arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   localparam int DEF_NUM_PORTS = 2;
   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 32;
   localparam int DEF_TIMEOUT   = 64;

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - combinational picker: first requester at or after ptr_i, wrapping
module rr_grant #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      logic found;
      int   j;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) j = j - N;
         if (!found && req_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port arbiter sharing one memory port; IDLE/BUSY/RESP FSM.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin grant; undefined gives fixed priority (port 0 first).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             port_ren,
   input  logic [NUM_PORTS-1:0]             port_wen,
   input  logic [NUM_PORTS*ADDR_W-1:0]      port_addr,
   input  logic [NUM_PORTS*DATA_W-1:0]      port_wdata,
   input  logic [NUM_PORTS*(DATA_W/8)-1:0]  port_bsel,
   output logic [NUM_PORTS*DATA_W-1:0]      port_rdata,
   output logic [NUM_PORTS-1:0]             port_ready,
   output logic [NUM_PORTS-1:0]             port_err,
   output logic                             nostall,
   output logic                             mem_ren,
   output logic                             mem_wen,
   output logic [ADDR_W-1:0]                mem_addr,
   output logic [DATA_W-1:0]                mem_wdata,
   output logic [DATA_W/8-1:0]              mem_bsel,
   input  logic [DATA_W-1:0]                mem_rdata,
   input  logic                             mem_ack
);

   localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int BSEL_W = DATA_W / 8;
   localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e                  state_q;
   logic [IDX_W-1:0]            g_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [NUM_PORTS*DATA_W-1:0] rdata_q;
   logic [NUM_PORTS-1:0]        ready_q;
   logic [NUM_PORTS-1:0]        err_q;
   logic                        ren_q, wen_q;
   logic [ADDR_W-1:0]           addr_q;
   logic [DATA_W-1:0]           wdata_q;
   logic [BSEL_W-1:0]           bsel_q;

   logic [NUM_PORTS-1:0]        req, gnt_oh;
   logic [IDX_W-1:0]            gnt_idx, ptr;
   logic                        timeout_hit;

   assign req = port_ren | port_wen;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr_q;
   assign ptr = ptr_q;
`else
   assign ptr = '0;
`endif

   rr_grant #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_grant (
      .req_i   (req),
      .ptr_i   (ptr),
      .grant_o (gnt_oh),
      .idx_o   (gnt_idx)
   );

   generate
      if (TIMEOUT > 0) begin : g_timeout
         assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         g_q     <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         ready_q <= '0;
         err_q   <= '0;
         ren_q   <= 1'b0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         bsel_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr_q   <= '0;
`endif
      end else begin
         ready_q <= '0;
         err_q   <= '0;
         case (state_q)
            IDLE: begin
               if (|gnt_oh) begin
                  // Write wins when both strobes are set on the granted port.
                  g_q     <= gnt_idx;
                  wen_q   <= port_wen[gnt_idx];
                  ren_q   <= ~port_wen[gnt_idx];
                  addr_q  <= port_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                  wdata_q <= port_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                  bsel_q  <= port_bsel[int'(gnt_idx)*BSEL_W +: BSEL_W];
                  cnt_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  if (ren_q) rdata_q[int'(g_q)*DATA_W +: DATA_W] <= mem_rdata;
                  ren_q      <= 1'b0;
                  wen_q      <= 1'b0;
                  ready_q[g_q] <= 1'b1;
                  state_q    <= RESP;
               end else if (timeout_hit) begin
                  ren_q      <= 1'b0;
                  wen_q      <= 1'b0;
                  ready_q[g_q] <= 1'b1;
                  err_q[g_q]   <= 1'b1;
                  state_q    <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
               ptr_q <= (int'(g_q) == NUM_PORTS - 1) ? '0 : g_q + 1'b1;
`endif
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign port_rdata = rdata_q;
   assign port_ready = ready_q;
   assign port_err   = err_q;
   assign nostall    = ~|(req & ~ready_q);
   assign mem_ren    = ren_q;
   assign mem_wen    = wen_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_bsel   = bsel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (2 ports, TIMEOUT=4)
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  port_ren, port_wen;
   logic [63:0] port_addr, port_wdata;
   logic [7:0]  port_bsel;
   logic [63:0] port_rdata;
   logic [1:0]  port_ready, port_err;
   logic        nostall, mem_ren, mem_wen;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_bsel;
   logic        mem_ack;

   mem_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .port_ren(port_ren), .port_wen(port_wen), .port_addr(port_addr),
      .port_wdata(port_wdata), .port_bsel(port_bsel), .port_rdata(port_rdata),
      .port_ready(port_ready), .port_err(port_err), .nostall(nostall),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_bsel(mem_bsel), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct { int pidx; logic [31:0] rdata; logic err; } rsp_t;
   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] bsel; } mtx_t;
   rsp_t exp_q[$];
   mtx_t mexp_q[$];

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // memory model
   bit          mem_enable = 1'b1;
   int          mem_wait = 0;
   logic [31:0] mem_data = '0;
   int          wcnt = 0;
   bit          ack_sent = 1'b0;

   always @(negedge clk) begin
      mtx_t m;
      mem_ack = 1'b0;
      if (!(mem_ren | mem_wen)) begin
         wcnt = 0;
         ack_sent = 1'b0;
      end else if (mem_enable && !ack_sent) begin
         if (wcnt == mem_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_data;
            ack_sent  = 1'b1;
            if (mexp_q.size() == 0) check("unexp_mem_tx", 1, 0);
            else begin
               m = mexp_q.pop_front();
               check("mem_wen", mem_wen, m.we);
               check("mem_ren", mem_ren, !m.we);
               check("mem_addr", mem_addr, m.addr);
               if (m.we) begin
                  check("mem_wdata", mem_wdata, m.wdata);
                  check("mem_bsel", mem_bsel, m.bsel);
               end
            end
         end else wcnt++;
      end
   end

   // response monitor
   always @(negedge clk) begin
      rsp_t e;
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            if (port_ready[i]) begin
               if (exp_q.size() == 0) check("unexp_ready", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  check("rsp_port", i, e.pidx);
                  check("rsp_rdata", port_rdata[i*32 +: 32], e.rdata);
                  check("rsp_err", port_err[i], e.err);
               end
            end
         end
         if ((port_err & ~port_ready) != 0) check("err_wo_ready", port_err & ~port_ready, 0);
      end
   end

   task automatic serve(input int p, input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] bsel, input int waits,
                        input logic [31:0] mdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input bit mem_on, output int lat);
      mem_wait   = waits;
      mem_data   = mdata;
      mem_enable = mem_on;
      exp_q.push_back('{p, exp_rdata, exp_err});
      if (mem_on) mexp_q.push_back('{wen, addr, wdata, bsel});
      @(posedge clk); #1;
      port_addr[p*32 +: 32]  = addr;
      port_wdata[p*32 +: 32] = wdata;
      port_bsel[p*4 +: 4]    = bsel;
      port_ren[p] = ren;
      port_wen[p] = wen;
      lat = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (port_ready[p]) break;
         lat++;
      end
      if (lat >= 40) check("serve_wait_expired", 0, 1);
      port_ren[p] = 1'b0;
      port_wen[p] = 1'b0;
   endtask

   initial begin
      int lat, done;
      int gp;
      reset = 1'b0;
      port_ren = '0; port_wen = '0; port_addr = '0; port_wdata = '0; port_bsel = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdata", port_rdata, 64'h0);
      check("rst_ready", port_ready, 0);
      check("rst_strobes", {mem_ren, mem_wen}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_nostall", nostall, 1);
      reset = 1'b1;
      @(negedge clk);

      // single zero-wait read on port 1, cycle by cycle
      mem_wait = 0; mem_data = 32'hDEADBEEF; mem_enable = 1'b1;
      exp_q.push_back('{1, 32'hDEADBEEF, 1'b0});
      mexp_q.push_back('{1'b0, 32'h100, 32'h0, 4'h0});
      @(posedge clk); #1;
      port_addr[63:32] = 32'h100; port_ren[1] = 1'b1;
      @(negedge clk);
      check("t1_c0_nostall", nostall, 0);
      check("t1_c0_ren", mem_ren, 0);
      @(negedge clk);
      check("t1_c1_ren", mem_ren, 1);
      check("t1_c1_nostall", nostall, 0);
      @(negedge clk);
      check("t1_c2_ready", port_ready, 2'b10);
      check("t1_c2_nostall", nostall, 1);
      check("t1_c2_ren", mem_ren, 0);
      port_ren[1] = 1'b0;
      @(negedge clk);
      check("t1_c3_ready", port_ready, 0);

      serve(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 0, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 1'b1, lat);
      check("rd0_latency", lat, 2);

      // write with 3 wait cycles leaves port_rdata alone
      serve(0, 1'b0, 1'b1, 32'h80, 32'h1234ABCD, 4'b0011, 3, 32'hFFFFFFFF, 32'hCAFE0001, 1'b0, 1'b1, lat);
      check("wr_latency", lat, 5);

      // no ack at all: timeout after TIMEOUT+1 busy cycles
      serve(1, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, lat);
      check("to_latency", lat, 6);
      @(negedge clk);
      check("to_single_pulse", {port_ready, port_err}, 0);
      check("to_back_idle", mem_ren, 0);
      mem_enable = 1'b1;

      // both ports requesting continuously
      mem_wait = 0; mem_data = 32'h11112222;
      for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         gp = k % 2;
`else
         gp = 0;
`endif
         exp_q.push_back('{gp, 32'h11112222, 1'b0});
         mexp_q.push_back('{1'b0, (gp == 1) ? 32'h200 : 32'h300, 32'h0, 4'h0});
      end
      @(posedge clk); #1;
      port_addr[31:0] = 32'h300; port_addr[63:32] = 32'h200; port_ren = 2'b11;
      done = 0;
      for (int c = 0; c < 60 && done < 4; c++) begin
         @(negedge clk);
         if (port_ready != 0) done++;
      end
      port_ren = '0;
      check("conc_count", done, 4);

      // ren and wen together: write wins
      serve(0, 1'b1, 1'b1, 32'h500, 32'h55AA55AA, 4'hF, 1, 32'h0, 32'h11112222, 1'b0, 1'b1, lat);
      check("rw_latency", lat, 3);

      // reset in the middle of BUSY
      mem_enable = 1'b0;
      @(posedge clk); #1;
      port_addr[31:0] = 32'h400; port_ren[0] = 1'b1;
      @(negedge clk); @(negedge clk);
      check("mid_busy_ren", mem_ren, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_ren", mem_ren, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_rdata", port_rdata, 64'h0);
      check("mid_rst_ready", port_ready, 0);
      port_ren = '0;
      #1;
      check("mid_rst_nostall", nostall, 1);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      serve(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0, 0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b1, lat);
      check("post_rst_latency", lat, 2);

      repeat (3) @(negedge clk);
      check("rsp_queue_empty", exp_q.size(), 0);
      check("mem_queue_empty", mexp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
